// File: rtl/alu_pkg.sv
// Shared ALU function encodings and arbiter state type used by the
// ALU-sharing arbiter and its ALU instance.
package alu_pkg;

  typedef logic [3:0] alu_fun_t;

  localparam alu_fun_t ALU_ADD  = 4'b0000;
  localparam alu_fun_t ALU_SLL  = 4'b0001;
  localparam alu_fun_t ALU_SLT  = 4'b0010;
  localparam alu_fun_t ALU_XOR  = 4'b0100;
  localparam alu_fun_t ALU_SRL  = 4'b0101;
  localparam alu_fun_t ALU_OR   = 4'b0110;
  localparam alu_fun_t ALU_AND  = 4'b0111;
  localparam alu_fun_t ALU_SUB  = 4'b1000;
  localparam alu_fun_t ALU_COPY = 4'b1001;
  localparam alu_fun_t ALU_SLTU = 4'b1011;
  localparam alu_fun_t ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/OTTER_ALU.sv
// Purely combinational 32-bit ALU; unknown function codes fall back to A+B.
module OTTER_ALU
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_fun_t    alu_fun,
  output logic [31:0] result
);

  // Function decode; shift amounts only use the low five bits of B
  always_comb begin
    result = a + b;
    case (alu_fun)
      ALU_ADD:  result = a + b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_SUB:  result = a - b;
      ALU_COPY: result = a;
      ALU_SLTU: result = (a < b) ? 32'd1 : 32'd0;
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one OTTER_ALU between NUM_REQ
// requesters: grant, one execute cycle, then hold the result until accepted.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*4-1:0]   req_fun,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);

  localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(NUM_REQ - 1);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  alu_fun_t        op_fun_q, op_fun_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic            resp_valid_q, resp_valid_d;
  logic            busy_q, busy_d;

  logic [ID_W:0]   pick_s;
  logic            pick_vld_s;
  logic [ID_W-1:0] pick_idx_s;
  logic            can_grant_s;
  logic [31:0]     sel_a_s;
  logic [31:0]     sel_b_s;
  alu_fun_t        sel_fun_s;
  logic [31:0]     alu_result_s;

  // Scan from last+1 upward with wrap; iterating farthest-first lets the
  // nearest valid requester overwrite earlier hits. MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0]   pick;
    logic [ID_W-1:0] idx;
    int              cand;
    pick = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last) + off) % NUM_REQ;
      idx  = ID_W'(cand);
      if (valid[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  OTTER_ALU u_alu (
    .a       (op_a_q),
    .b       (op_b_q),
    .alu_fun (op_fun_q),
    .result  (alu_result_s)
  );

  // Grant decision; ready is combinational and suppressed while in reset
  always_comb begin
    pick_s      = rr_pick(req_valid, last_grant_q);
    pick_vld_s  = pick_s[ID_W];
    pick_idx_s  = pick_s[ID_W-1:0];
    can_grant_s = RST_N && pick_vld_s &&
                  ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
    if (can_grant_s) begin
      req_ready = NUM_REQ'(1) << pick_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_a_s   = 32'd0;
    sel_b_s   = 32'd0;
    sel_fun_s = ALU_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == pick_idx_s) begin
        sel_a_s   = req_a[32*i +: 32];
        sel_b_s   = req_b[32*i +: 32];
        sel_fun_s = req_fun[4*i +: 4];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  // Next-state logic for the IDLE/EXEC/RESP sequencer
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_fun_d     = op_fun_q;
    op_id_d      = op_id_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      IDLE: begin
        if (can_grant_s) begin
          op_a_d       = sel_a_s;
          op_b_d       = sel_b_s;
          op_fun_d     = sel_fun_s;
          op_id_d      = pick_idx_s;
          last_grant_d = pick_idx_s;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        resp_data_d  = alu_result_s;
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (can_grant_s) begin
            op_a_d       = sel_a_s;
            op_b_d       = sel_b_s;
            op_fun_d     = sel_fun_s;
            op_id_d      = pick_idx_s;
            last_grant_d = pick_idx_s;
            state_d      = EXEC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_GRANT_RST;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_fun_q     <= ALU_ADD;
      op_id_q      <= '0;
      resp_data_q  <= 32'd0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_fun_q     <= op_fun_d;
      op_id_q      <= op_id_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a response scoreboard fed on
// every request handshake and drained on every response handshake.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  CLK = 1'b0;
  logic                  RST_N;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_fun;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [ID_W-1:0]       resp_id;
  logic                  busy;

  typedef struct {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   grants_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_fun    (req_fun),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] fun);
    logic [4:0] sh;
    sh = b[4:0];
    case (fun)
      4'b0000: return a + b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1000: return a - b;
      4'b1001: return a;
      4'b1011: return (a < b) ? 32'd1 : 32'd0;
      4'b1101: return $unsigned($signed(a) >>> sh);
      default: return a + b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] fun);
    if (i == 0) begin
      req_valid[0] = v; req_a[31:0] = a; req_b[31:0] = b; req_fun[3:0] = fun;
    end else begin
      req_valid[1] = v; req_a[63:32] = a; req_b[63:32] = b; req_fun[7:4] = fun;
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  // One uncontended op with resp_ready high: accept, EXEC, RESP, back to IDLE
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] fun, input logic [31:0] exp_data, input string tag);
    set_req(idx, 1'b1, a, b, fun);
    resp_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1 << idx);
    cyc();
    set_req(idx, 1'b0, 32'd0, 32'd0, 4'd0);
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    chk({tag, "_exec_rvalid"}, 32'(resp_valid), 32'd0);
    cyc();
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_id"}, 32'(resp_id), 32'(idx));
    cyc();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard: responses are popped before same-edge grants are pushed
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      sb_q.delete();
    end else begin
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (resp_valid && resp_ready) begin
        chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_data", resp_data, e.data);
          chk("sb_id", 32'(resp_id), 32'(e.id));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.data = model(req_a[32*i +: 32], req_b[32*i +: 32], req_fun[4*i +: 4]);
          e.id   = ID_W'(i);
          sb_q.push_back(e);
          grants_q.push_back(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    RST_N = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_fun = '0;
    resp_ready = 1'b0;
    #1;
    RST_N = 1'b0;
    req_valid = 2'b11;
    #2;
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    cyc();
    cyc();
    RST_N = 1'b1;
    cyc();

    // Contention: both valid continuously, grants alternate from requester 0
    grants_q.delete();
    set_req(0, 1'b1, 32'd10, 32'd3, 4'b1000);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    resp_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'(req_ready), 32'd1);
    repeat (8) cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    cyc();
    cyc();
    chk("rr_grant_count", 32'(grants_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < grants_q.size()) chk("rr_grant_order", 32'(grants_q[k]), 32'(exp_g[k]));
    end

    do_op(0, 32'd5, 32'd7, 4'b0000, 32'd12, "single");
    do_op(0, 32'd1, 32'h21, 4'b0001, 32'd2, "sll");
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'b1011, 32'd0, "sltu");
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, "slt");
    do_op(0, 32'd3, 32'd4, 4'b1111, 32'd7, "unlisted");

    // Backpressure: SRA result held while r0 waits, r0 granted on the release cycle
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'b1101);
    resp_ready = 1'b0;
    #1;
    chk("bp_ready_r1", 32'(req_ready), 32'd2);
    cyc();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(0, 1'b1, 32'd1, 32'd2, 4'b0000);
    #1;
    chk("bp_exec_ready", 32'(req_ready), 32'd0);
    cyc();
    repeat (5) begin
      chk("bp_rvalid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_data, 32'hF800_0000);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      cyc();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("bp_exec_rvalid", 32'(resp_valid), 32'd0);
    cyc();
    chk("bp_r0_data", resp_data, 32'd3);
    cyc();

    // Withdrawn request during a stalled RESP must not move last_grant
    set_req(0, 1'b1, 32'd9, 32'd9, 4'b0000);
    resp_ready = 1'b0;
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    cyc();
    set_req(1, 1'b1, 32'd4, 32'd5, 4'b0000);
    #1;
    chk("wd_ready_a", 32'(req_ready), 32'd0);
    cyc();
    chk("wd_ready_b", 32'(req_ready), 32'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    cyc();
    chk("wd_held_id", 32'(resp_id), 32'd0);
    chk("wd_held_data", resp_data, 32'd18);
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0000);
    set_req(1, 1'b1, 32'd6, 32'd7, 4'b0100);
    resp_ready = 1'b1;
    #1;
    chk("wd_next_grant_r1", 32'(req_ready), 32'd2);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    cyc();
    chk("wd_r1_id", 32'(resp_id), 32'd1);
    chk("wd_r1_data", resp_data, 32'd1);
    cyc();

    // Reset during EXEC discards the op and restores requester-0 priority
    set_req(1, 1'b1, 32'd2, 32'd3, 4'b0000);
    resp_ready = 1'b1;
    cyc();
    set_req(0, 1'b1, 32'd20, 32'd22, 4'b0000);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(resp_valid), 32'd0);
    chk("mid_rst_data", resp_data, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    cyc();
    RST_N = 1'b1;
    #1;
    chk("post_rst_grant_r0", 32'(req_ready), 32'd1);
    chk("post_rst_rvalid", 32'(resp_valid), 32'd0);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    cyc();
    chk("post_rst_id", 32'(resp_id), 32'd0);
    chk("post_rst_data", resp_data, 32'd42);
    cyc();
    cyc();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
